// File: rtl/mult_seq_ctrl_pkg.sv
// mult_seq_ctrl_pkg
//   Shared definitions for the digit-serial multiplier controller:
//   FSM state encodings and the digit width used to split operands.
package mult_seq_ctrl_pkg;

    // FSM state encodings (2-bit, fixed values)
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of one operand digit; each digit-pair product is 2*DIG_W bits
    localparam int DIG_W = 2;

endpackage

// File: rtl/mult_seq_ctrl_mul2.sv
// mul2_core
//   Purely combinational 2-bit x 2-bit unsigned multiplier.
//   Ports:
//     a : input  [1:0]  first digit
//     b : input  [1:0]  second digit
//     p : output [3:0]  unsigned product a*b (max 9, never overflows)
module mul2_core
    import mult_seq_ctrl_pkg::*;
(
    input  logic [DIG_W-1:0]   a,
    input  logic [DIG_W-1:0]   b,
    output logic [2*DIG_W-1:0] p
);

    assign p = {{DIG_W{1'b0}}, a} * {{DIG_W{1'b0}}, b};

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//   Computes an unsigned W x W product by time-sharing a single 2x2 digit
//   multiplier. One digit-pair product is formed and shift-accumulated per
//   clock; a start/busy/done handshake allows back-to-back operations.
//   Ports:
//     clk   : input         system clock, rising edge
//     rst   : input         synchronous active-high reset
//     start : input         request a multiplication
//     A, B  : input  [W-1]  operands, captured on the accepting edge
//     busy  : output        high while digit products are accumulated
//     done  : output        one-cycle pulse when y becomes valid
//     y     : output [2W-1] product A*B, held until the next completion
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int W = 8
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] y
);

    localparam int D  = W / DIG_W;
    localparam int PW = 2 * W;
    // Counter width; a single-digit build still needs a 1-bit counter
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    // Shift amount reaches 2W-4, so this width always suffices
    localparam int SW = $clog2(PW) + 1;
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    state_t          state_reg;
    logic [W-1:0]    a_reg, b_reg;
    logic [PW-1:0]   acc_reg;
    logic [PW-1:0]   y_reg;
    logic [CW-1:0]   i_reg, j_reg;
    logic            busy_reg, done_reg;

    // Digit views of the latched operands, selected by the counters
    logic [DIG_W-1:0] a_dig [D];
    logic [DIG_W-1:0] b_dig [D];

    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_digits
            assign a_dig[gi] = a_reg[DIG_W*gi +: DIG_W];
            assign b_dig[gi] = b_reg[DIG_W*gi +: DIG_W];
        end
    endgenerate

    logic [DIG_W-1:0]   a_sel, b_sel;
    logic [2*DIG_W-1:0] prod;
    logic [SW-1:0]      shamt;
    logic [PW-1:0]      term;
    logic [PW-1:0]      sum_next;

    assign a_sel = a_dig[i_reg];
    assign b_sel = b_dig[j_reg];

    mul2_core u_mul2_core (
        .a (a_sel),
        .b (b_sel),
        .p (prod)
    );

    assign shamt    = SW'(DIG_W) * (SW'(i_reg) + SW'(j_reg));
    assign term     = PW'(prod) << shamt;
    assign sum_next = acc_reg + term;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            y_reg     <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        acc_reg   <= '0;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= S_RUN;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if ((i_reg == LAST) && (j_reg == LAST)) begin
                        // Final product goes straight to y from the adder
                        y_reg     <= sum_next;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        acc_reg <= sum_next;
                        if (j_reg == LAST) begin
                            j_reg <= '0;
                            i_reg <= i_reg + CW'(1);
                        end else begin
                            j_reg <= j_reg + CW'(1);
                        end
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign y    = y_reg;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [7:0]  a8, b8;
    logic [1:0]  a2, b2;
    logic        busy, done, busy2, done2;
    logic [15:0] y;
    logic [3:0]  y2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a8), .B(b8),
        .busy(busy), .done(done), .y(y)
    );

    mult_seq_ctrl #(.W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2),
        .busy(busy2), .done(done2), .y(y2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    // One full operation: pulse start, wait for done, check latency/busy/y
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_y, input logic [15:0] prev_y);
        int n;
        int busy_cnt;
        bit y_moved;
        a8 = a; b8 = b; start = 1'b1;
        tick();
        start = 1'b0; a8 = 8'hxx; b8 = 8'hxx;
        n = 0; busy_cnt = 0; y_moved = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            if (y !== prev_y) y_moved = 1;
            tick();
            n++;
        end
        check_val({tag, " latency"}, n, 16);
        check_val({tag, " busy_cycles"}, busy_cnt, 16);
        check_val({tag, " y_stable"}, {31'd0, y_moved}, 0);
        check_val({tag, " busy_at_done"}, {31'd0, busy}, 0);
        check_val({tag, " y"}, {16'd0, y}, {16'd0, exp_y});
        tick();
        check_val({tag, " done_one_cycle"}, {31'd0, done}, 0);
        check_val({tag, " y_hold"}, {16'd0, y}, {16'd0, exp_y});
    endtask

    initial begin
        int n, dcount, gaps, pulses;
        rst = 1'b1; start = 0; start2 = 0; a8 = 0; b8 = 0; a2 = 0; b2 = 0;
        tick(); tick();
        check_val("reset busy", {31'd0, busy}, 0);
        check_val("reset done", {31'd0, done}, 0);
        check_val("reset y", {16'd0, y}, 0);
        check_val("reset y2", {28'd0, y2}, 0);
        rst = 1'b0;
        tick();

        run_op("0D*0B", 8'h0D, 8'h0B, 16'h008F, 16'h0000);
        run_op("FF*FF", 8'hFF, 8'hFF, 16'hFE01, 16'h008F);
        run_op("00*FF", 8'h00, 8'hFF, 16'h0000, 16'hFE01);
        run_op("80*02", 8'h80, 8'h02, 16'h0100, 16'h0000);

        // Start while busy must be ignored
        a8 = 8'h12; b8 = 8'h34; start = 1'b1;
        tick();
        start = 1'b0; n = 0;
        repeat (4) begin tick(); n++; end
        a8 = 8'hFF; b8 = 8'hFF; start = 1'b1;
        tick(); n++;
        start = 1'b0;
        while (!done && n < 40) begin tick(); n++; end
        check_val("ignore latency", n, 16);
        check_val("ignore y", {16'd0, y}, 32'h03A8);
        dcount = 0;
        repeat (20) begin tick(); if (done) dcount++; end
        check_val("ignore extra_done", dcount, 0);

        // Reset mid-operation aborts with no done pulse
        a8 = 8'h10; b8 = 8'h10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort busy", {31'd0, busy}, 0);
        check_val("abort done", {31'd0, done}, 0);
        check_val("abort y", {16'd0, y}, 0);
        dcount = 0;
        repeat (20) begin tick(); if (done || busy) dcount++; end
        check_val("abort quiet", dcount, 0);
        run_op("03*05", 8'h03, 8'h05, 16'h000F, 16'h0000);

        // Start held high: back-to-back operations every 17 cycles
        a8 = 8'h02; b8 = 8'h03; start = 1'b1;
        tick();
        n = 0; gaps = 0; pulses = 0;
        while (pulses < 3 && n < 100) begin
            if (done) begin
                check_val($sformatf("b2b interval%0d", pulses), n, (pulses == 0) ? 16 : 17);
                check_val($sformatf("b2b y%0d", pulses), {16'd0, y}, 32'h0006);
                check_val($sformatf("b2b busy%0d", pulses), {31'd0, busy}, 0);
                pulses++;
                n = 0;
            end else if (!busy) begin
                gaps++;
            end
            tick();
            n++;
        end
        check_val("b2b pulses", pulses, 3);
        check_val("b2b busy_gaps", gaps, 0);
        start = 1'b0;
        while (!done && n < 40) begin tick(); n++; end
        tick();
        check_val("b2b idle busy", {31'd0, busy}, 0);
        check_val("b2b idle done", {31'd0, done}, 0);

        // W=2 instance: exhaustive, one-cycle latency
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                a2 = 2'(ia); b2 = 2'(ib); start2 = 1'b1;
                tick();
                start2 = 1'b0;
                check_val($sformatf("w2 %0d*%0d busy", ia, ib), {31'd0, busy2}, 1);
                tick();
                check_val($sformatf("w2 %0d*%0d done", ia, ib), {31'd0, done2}, 1);
                check_val($sformatf("w2 %0d*%0d y", ia, ib), {28'd0, y2}, ia * ib);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
